// File: rtl/mac_ofm_packer_pkg.sv
// Shared types and constants for the MAC lane output-feature-map packer.
// Optional monitor feature is enabled by defining MAC_OFM_PACKER_MONITOR_EN.
package mac_ofm_packer_pkg;

  localparam int MAC_WORD_W     = 32;
  localparam int MAC_OFM_PACK_N = 4;

  // Per-result stream word produced by one MAC lane.
  typedef struct packed {
    logic [MAC_WORD_W-1:0] data;
    logic                  output_end;
  } mac_lane_ofm_port;

  // Per-result floating-point status from the lane.
  typedef struct packed {
    logic is_nan;
    logic is_inf;
  } mac_lane_monitor;

  // One packed beat for the default packing factor.
  typedef struct packed {
    logic [MAC_WORD_W*MAC_OFM_PACK_N-1:0] data;
    logic [MAC_OFM_PACK_N-1:0]            word_valid;
    logic                                 last;
  } mac_ofm_beat_port;

  // FILL accumulates words; COMMIT qualifies the FIFO write of a finished beat.
  typedef enum logic {
    PACK_FILL,
    PACK_COMMIT
  } pack_state_e;

  // Flat width of a beat {data, word_valid, last} for a given packing factor.
  function automatic int beat_width(input int pack_n);
    return MAC_WORD_W * pack_n + pack_n + 1;
  endfunction

endpackage

// File: rtl/mac_ofm_packer_if.sv
// Result-in / beat-out handshake bundle of the OFM packer.
// The packer uses the slave modport; the lane/writeback side uses master.
interface mac_ofm_packer_if
  import mac_ofm_packer_pkg::*;
#(
  parameter int PACK_N = MAC_OFM_PACK_N
);

  logic                         i_ofm_valid;
  mac_lane_ofm_port             i_ofm;
  logic                         o_ofm_ready;
  logic                         o_beat_valid;
  logic [MAC_WORD_W*PACK_N-1:0] o_beat_data;
  logic [PACK_N-1:0]            o_beat_word_valid;
  logic                         o_beat_last;
  logic                         i_beat_ready;

  modport slave (
    input  i_ofm_valid, i_ofm, i_beat_ready,
    output o_ofm_ready, o_beat_valid, o_beat_data, o_beat_word_valid, o_beat_last
  );

  modport master (
    output i_ofm_valid, i_ofm, i_beat_ready,
    input  o_ofm_ready, o_beat_valid, o_beat_data, o_beat_word_valid, o_beat_last
  );

endinterface

// File: rtl/mac_ofm_fifo.sv
// Synchronous FIFO of packed beats; head is the oldest entry.
// Push when full and pop when empty are ignored.
module mac_ofm_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  // NOTE: state registers use <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage write.
  // NOTE: the array has no reset; stale entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mac_ofm_packer.sv
// Packs PACK_N lane results into wide beats, buffers them, and presents them
// with a valid/ready handshake. output_end flushes a partial beat immediately.
// Define MAC_OFM_PACKER_MONITOR_EN to add NaN/Inf monitor ports and counters.
module mac_ofm_packer
  import mac_ofm_packer_pkg::*;
#(
  parameter int PACK_N     = MAC_OFM_PACK_N,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  mac_ofm_packer_if.slave     bus
`ifdef MAC_OFM_PACKER_MONITOR_EN
  ,
  input  mac_lane_monitor     i_monitor,
  input  logic                i_monitor_clear,
  output logic                o_nan_seen,
  output logic                o_inf_seen,
  output logic [15:0]         o_nan_count
`endif
);

  localparam int            CW       = (PACK_N > 1) ? $clog2(PACK_N) : 1;
  localparam int            BEAT_W   = beat_width(PACK_N);
  localparam logic [CW-1:0] CNT_LAST = CW'(PACK_N - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0]                cnt;
  logic [MAC_WORD_W*PACK_N-1:0] pack_data;
  logic [PACK_N-1:0]            pack_mask;
  logic [MAC_WORD_W*PACK_N-1:0] fill_data;
  logic [PACK_N-1:0]            fill_mask;
  pack_state_e                  pack_state;
  logic                         accept;
  logic                         rst_q;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic [BEAT_W-1:0]            fifo_head;

  assign accept          = bus.i_ofm_valid && bus.o_ofm_ready;
  // Ready comes only from registers, so a pop cannot open the input in the same cycle.
  assign bus.o_ofm_ready = !fifo_full && !rst_q;

  // Merge the incoming word into the pack register and decide whether the beat commits.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    fill_data = pack_data;
    fill_mask = pack_mask;
    fill_data[int'(cnt)*MAC_WORD_W +: MAC_WORD_W] = bus.i_ofm.data;
    fill_mask[cnt] = 1'b1;
    pack_state = PACK_FILL;
    if (accept && (cnt == CNT_LAST || bus.i_ofm.output_end)) pack_state = PACK_COMMIT;
  end

  // Pack counter and pack register; a committed beat leaves a clean register behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_q     <= 1'b1;
      cnt       <= '0;
      pack_data <= '0;
      pack_mask <= '0;
    end else begin
      rst_q <= 1'b0;
      if (pack_state == PACK_COMMIT) begin
        cnt       <= '0;
        pack_data <= '0;
        pack_mask <= '0;
      end else if (accept) begin
        cnt       <= cnt + CNT_ONE;
        pack_data <= fill_data;
        pack_mask <= fill_mask;
      end
    end
  end

  mac_ofm_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pack_state == PACK_COMMIT),
    .din   ({fill_data, fill_mask, bus.i_ofm.output_end}),
    .pop   (bus.i_beat_ready),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Beat outputs are forced to zero whenever nothing is buffered.
  always_comb begin
    bus.o_beat_valid = !fifo_empty;
    {bus.o_beat_data, bus.o_beat_word_valid, bus.o_beat_last} = '0;
    if (!fifo_empty) {bus.o_beat_data, bus.o_beat_word_valid, bus.o_beat_last} = fifo_head;
  end

`ifdef MAC_OFM_PACKER_MONITOR_EN
  // Sticky NaN/Inf flags and saturating NaN count over accepted results; clear wins.
  always_ff @(posedge clk) begin
    if (rst || i_monitor_clear) begin
      o_nan_seen  <= 1'b0;
      o_inf_seen  <= 1'b0;
      o_nan_count <= '0;
    end else if (accept) begin
      if (i_monitor.is_nan) begin
        o_nan_seen <= 1'b1;
        if (o_nan_count != 16'hFFFF) o_nan_count <= o_nan_count + 16'd1;
      end
      if (i_monitor.is_inf) o_inf_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_ofm_packer.sv
// Directed bench for mac_ofm_packer with a beat scoreboard.
// Define MAC_OFM_PACKER_MONITOR_EN to also exercise the monitor feature.
module tb_mac_ofm_packer;
  import mac_ofm_packer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mac_ofm_packer_if #(.PACK_N(MAC_OFM_PACK_N)) bus ();

`ifdef MAC_OFM_PACKER_MONITOR_EN
  mac_lane_monitor mon;
  logic            mon_clear;
  logic            nan_seen;
  logic            inf_seen;
  logic [15:0]     nan_count;
`endif

  mac_ofm_packer #(
    .PACK_N     (MAC_OFM_PACK_N),
    .FIFO_DEPTH (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus)
`ifdef MAC_OFM_PACKER_MONITOR_EN
    ,
    .i_monitor       (mon),
    .i_monitor_clear (mon_clear),
    .o_nan_seen      (nan_seen),
    .o_inf_seen      (inf_seen),
    .o_nan_count     (nan_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;

  // Scoreboard of beats the bench expects, oldest first.
  mac_ofm_beat_port sb [$];

  // Reference packing state.
  logic [127:0] exp_data;
  logic [3:0]   exp_mask;
  int           exp_cnt;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_data = '0;
    exp_mask = '0;
    exp_cnt  = 0;
  endtask

  task automatic model_accept(input logic [31:0] d, input logic e);
    mac_ofm_beat_port b;
    exp_data[exp_cnt*32 +: 32] = d;
    exp_mask[exp_cnt] = 1'b1;
    if (exp_cnt == 3 || e) begin
      b.data       = exp_data;
      b.word_valid = exp_mask;
      b.last       = e;
      sb.push_back(b);
      model_reset();
    end else begin
      exp_cnt++;
    end
  endtask

  // Called at a negedge: drive one cycle of inputs, score any pop, model any accept.
  task automatic drive_cycle(input logic v, input logic [31:0] d, input logic e, input logic br);
    logic acc;
    logic pop;
    mac_ofm_beat_port b;
    bus.i_ofm_valid  = v;
    bus.i_ofm        = '{data: d, output_end: e};
    bus.i_beat_ready = br;
    #1;
    acc = v && bus.o_ofm_ready;
    pop = bus.o_beat_valid && br;
    if (pop) begin
      check("beat_expected", 128'(sb.size() != 0), 128'(1));
      if (sb.size() != 0) begin
        b = sb.pop_front();
        check("beat_data", bus.o_beat_data, b.data);
        check("beat_mask", 128'(bus.o_beat_word_valid), 128'(b.word_valid));
        check("beat_last", 128'(bus.o_beat_last), 128'(b.last));
      end
    end
    if (acc) begin
      model_accept(d, e);
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check("drain_sb_empty", 128'(sb.size()), 128'(0));
    check("drain_valid_low", 128'(bus.o_beat_valid), 128'(0));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, 128'(bus.o_beat_valid), 128'(0));
    check({tag, "_data"},  bus.o_beat_data, 128'(0));
    check({tag, "_mask"},  128'(bus.o_beat_word_valid), 128'(0));
    check({tag, "_last"},  128'(bus.o_beat_last), 128'(0));
  endtask

  initial begin
    int base;
    rst = 1'b1;
    bus.i_ofm_valid  = 1'b0;
    bus.i_ofm        = '0;
    bus.i_beat_ready = 1'b0;
`ifdef MAC_OFM_PACKER_MONITOR_EN
    mon       = '0;
    mon_clear = 1'b0;
`endif
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", 128'(bus.o_ofm_ready), 128'(0));
    check_outputs_zero("rst");
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 128'(bus.o_ofm_ready), 128'(1));

    // Eight full-width results form two beats; first beat visible one cycle after word 4.
    for (int i = 1; i <= 4; i++) drive_cycle(1'b1, 32'(i), 1'b0, 1'b1);
    check("lat_valid", 128'(bus.o_beat_valid), 128'(1));
    check("lat_data", bus.o_beat_data, 128'h00000004_00000003_00000002_00000001);
    for (int i = 5; i <= 8; i++) drive_cycle(1'b1, 32'(i), 1'b0, 1'b1);
    drain();

    // output_end flushes a partial beat; the next result restarts at word 0.
    drive_cycle(1'b1, 32'hA, 1'b0, 1'b1);
    drive_cycle(1'b1, 32'hB, 1'b1, 1'b1);
    check("end_data", bus.o_beat_data, 128'h0000000B_0000000A);
    check("end_mask", 128'(bus.o_beat_word_valid), 128'(4'b0011));
    check("end_last", 128'(bus.o_beat_last), 128'(1));
    drive_cycle(1'b1, 32'hC, 1'b1, 1'b1);
    check("w0_end_data", bus.o_beat_data, 128'h0000000C);
    check("w0_end_mask", 128'(bus.o_beat_word_valid), 128'(4'b0001));
    drain();

    // Backpressure: four beats fill the FIFO and input stalls after the 16th accept.
    base = n_acc;
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 32'h100 + 32'(n_acc - base), 1'b0, 1'b0);
    check("full_accepts", 128'(n_acc - base), 128'(16));
    check("full_ready_low", 128'(bus.o_ofm_ready), 128'(0));
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 32'h100 + 32'(n_acc - base), 1'b0, 1'b0);
    check("no_17th_accept", 128'(n_acc - base), 128'(16));
    drive_cycle(1'b1, 32'h100 + 32'(n_acc - base), 1'b0, 1'b1);
    check("pop_no_same_cycle_accept", 128'(n_acc - base), 128'(16));
    check("ready_after_pop", 128'(bus.o_ofm_ready), 128'(1));
    check("valid_after_one_pop", 128'(bus.o_beat_valid), 128'(1));
    drain();

    // Two beats buffered, then push and pop every cycle for ten cycles.
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, 32'h300 + 32'(i), 1'b1, 1'b1);
      check("pp_ready", 128'(bus.o_ofm_ready), 128'(1));
      check("pp_valid", 128'(bus.o_beat_valid), 128'(1));
      check("pp_sb_depth", 128'(sb.size()), 128'(2));
    end
    drain();

    // Reset with a partial beat and three buffered beats discards everything.
    for (int i = 0; i < 14; i++) drive_cycle(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
    bus.i_ofm_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    sb.delete();
    model_reset();
    check("midrst_ready", 128'(bus.o_ofm_ready), 128'(0));
    check_outputs_zero("midrst");
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_back", 128'(bus.o_ofm_ready), 128'(1));
    for (int i = 1; i <= 4; i++) drive_cycle(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
    check("clean_data", bus.o_beat_data, 128'h00000504_00000503_00000502_00000501);
    check("clean_mask", 128'(bus.o_beat_word_valid), 128'(4'b1111));
    drain();

`ifdef MAC_OFM_PACKER_MONITOR_EN
    // Monitor flags, clear priority and count saturation.
    mon = '{is_nan: 1'b1, is_inf: 1'b0};
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 32'h600 + 32'(i), 1'b0, 1'b1);
    mon = '{is_nan: 1'b0, is_inf: 1'b1};
    drive_cycle(1'b1, 32'h603, 1'b0, 1'b1);
    check("mon_count3", 128'(nan_count), 128'(3));
    check("mon_nan_seen", 128'(nan_seen), 128'(1));
    check("mon_inf_seen", 128'(inf_seen), 128'(1));
    mon = '{is_nan: 1'b1, is_inf: 1'b1};
    mon_clear = 1'b1;
    drive_cycle(1'b1, 32'h604, 1'b1, 1'b1);
    mon_clear = 1'b0;
    check("mon_clr_count", 128'(nan_count), 128'(0));
    check("mon_clr_nan", 128'(nan_seen), 128'(0));
    check("mon_clr_inf", 128'(inf_seen), 128'(0));
    mon = '{is_nan: 1'b1, is_inf: 1'b0};
    for (int i = 0; i < 70000; i++) drive_cycle(1'b1, 32'(i), 1'b0, 1'b1);
    check("mon_saturate", 128'(nan_count), 128'(16'hFFFF));
    mon = '0;
    drain();
`endif

    check("final_sb_empty", 128'(sb.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_ofm_packer.md
Name: mac_ofm_packer

Overview:
- Downstream stage of one MAC lane.
- Consumes the lane's per-result `mac_lane_ofm_port` stream (32-bit result plus `output_end`).
- Packs PACK_N consecutive results into one wide beat and buffers beats in a small FIFO.
- Presents beats to the writeback/DMA side with a valid/ready handshake and a per-word valid mask.
- A packet ends on `output_end`; any partial beat is flushed immediately.

Parameters:
- PACK_N, 4: 32-bit results per output beat. Power of two, ≥2.
- FIFO_DEPTH, 4: beats buffered. Power of two, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous, active-high.
- i_ofm_valid  in  1  lane result valid.
- i_ofm  in  33  `mac_lane_ofm_port` {data[31:0], output_end}.
- o_ofm_ready  out  1  packer can accept a result.
- o_beat_valid  out  1  head beat valid.
- o_beat_data  out  32*PACK_N  packed results; word k at bits [32k+31:32k].
- o_beat_word_valid  out  PACK_N  per-word valid mask.
- o_beat_last  out  1  beat contains the packet's `output_end` word.
- i_beat_ready  in  1  consumer accepts head beat.

Behaviour:
- Reset values: o_ofm_ready=0 during the reset cycle, 1 the cycle after. o_beat_valid=0, o_beat_data=0, o_beat_word_valid=0, o_beat_last=0. Pack counter, pack register and FIFO pointers/count are all 0.
- Reset mid-operation discards the partial pack and all buffered beats. No beat is emitted for them.
- Input handshake:
  - A result is accepted when i_ofm_valid && o_ofm_ready.
  - o_ofm_ready = !fifo_full, registered-equivalent. It does not depend on i_beat_ready in the same cycle.
  - When the FIFO is full, a same-cycle pop does not enable a same-cycle accept.
- Pack counter `cnt` (0..PACK_N-1), two-state FSM FILL / COMMIT:
  - FILL, on accept: write data into word `cnt` and set mask bit `cnt`.
  - If cnt==PACK_N-1 or output_end=1: the completed beat (data, mask, last=output_end) is written to the FIFO at the same clock edge, cnt resets to 0 and the pack register is cleared.
  - Otherwise cnt increments.
  - COMMIT is the single-cycle write qualifier, not a stall state. Back-to-back accepts are allowed every cycle.
- Unused words of a partial beat are driven 0 with mask bit 0.
- output_end on word 0 gives a beat with mask 0…01 and last=1.
- Latency: a result that completes a beat, accepted in cycle T, appears at the FIFO head with o_beat_valid=1 in cycle T+1 when the FIFO was empty.
- Output handshake:
  - The beat pops when o_beat_valid && i_beat_ready.
  - o_beat_* hold stable while valid and not ready.
  - Output signals are 0 when the FIFO is empty.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointers wrap modulo FIFO_DEPTH. full = count==FIFO_DEPTH; empty = count==0.
- Results never reorder. No result is dropped or duplicated.
- i_ofm is ignored when i_ofm_valid=0, or when o_ofm_ready=0 (input holds).

Optional Feature:
- Macro MAC_OFM_PACKER_MONITOR_EN.
- When defined, the following ports are added:
  - i_monitor (`mac_lane_monitor`, 2): sampled with each accepted result.
  - i_monitor_clear (1): synchronous clear.
  - o_nan_seen, o_inf_seen (1 each): sticky flags.
  - o_nan_count (16): saturating count of accepted results with is_nan=1; holds at 16'hFFFF.
- All monitor state resets to 0. i_monitor_clear clears it the next cycle.
- A clear coinciding with a flagged accept results in 0: the clear wins.
- When not defined, these ports and their logic are absent; the datapath is identical.

Decomposition:
- mac_pkg gains:
  - constant MAC_OFM_PACK_N=4;
  - typedef `mac_ofm_beat_port` packed {data[32*MAC_OFM_PACK_N], word_valid[MAC_OFM_PACK_N], last}.
- `mac_lane_ofm_port` and `mac_lane_monitor` are reused unchanged.
- One sub-module: mac_ofm_fifo, a synchronous FIFO with parameters WIDTH and DEPTH and ports push/pop/full/empty/head. It is instantiated with WIDTH = 32*PACK_N+PACK_N+1.

Test Plan:
- Reset, then 8 results 0x1..0x8, all output_end=0, i_beat_ready=1 → two beats:
  - {4,3,2,1} with mask 1111, last=0;
  - {8,7,6,5} with mask 1111, last=0.
  - First beat is valid 1 cycle after result 4 is accepted.
- Results 0xA, 0xB with output_end on 0xB → one beat with data {0,0,B,A}, mask 0011, last=1. A following result 0xC starts at word 0.
- i_beat_ready=0, 16 results streamed → o_ofm_ready falls after the 16th accept (4 beats buffered) and no 17th accept occurs. Then ready=1 for 1 cycle → exactly one pop, and o_ofm_ready returns the following cycle.
- FIFO holds 2 beats; simultaneous push and pop every cycle for 10 cycles → count stays 2, beats come out in order, and pointers wrap correctly.
- Assert rst for 1 cycle after 2 words of a beat plus 3 buffered beats → all outputs 0. The next 4 results form a clean beat with no stale words.
- (MAC_OFM_PACKER_MONITOR_EN) Three is_nan results and one is_inf result → o_nan_count=3, both flags set. i_monitor_clear → all 0 next cycle. 70000 nan results → count saturates at 0xFFFF.
